// File: rtl/net_batch_runner.sv
// Batch-inference sequencer: holds DEPTH input vectors with expected labels,
// drives them one at a time through an external net, stores the raw outputs,
// classifies each against THRESH and keeps pass/fail counts.
module net_batch_runner #(
    parameter int          I       = 2,
    parameter int          O       = 1,
    parameter int          AW      = 2,
    parameter logic [31:0] THRESH  = 32'h3f000000,
    parameter int          TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_addr,
    input  logic [32*I-1:0]   ld_x,
    input  logic [O-1:0]      ld_exp,
    input  logic [AW:0]       n_vec,
    input  logic              stop_on_fail,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       pass_cnt,
    output logic [AW:0]       fail_cnt,
    output logic              err_timeout,
    input  logic [AW-1:0]     rd_addr,
    output logic [32*O-1:0]   rd_y,
    output logic              net_start,
    output logic [32*I-1:0]   net_x,
    input  logic [32*O-1:0]   net_y,
    input  logic              net_done
);

    localparam int DEPTH = 1 << AW;
    localparam int WDW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [32*I-1:0] in_buf  [DEPTH];
    logic [O-1:0]    exp_buf [DEPTH];
    logic [32*O-1:0] res_buf [DEPTH];

    logic [AW-1:0]  idx, idx_nx;
    logic [AW:0]    n_run;
    logic [AW:0]    n_clamp;
    logic           sof;
    logic [WDW-1:0] wd_cnt;
    logic           net_done_p1;
    logic           done_rise;
    logic           wd_expire;
    logic           last_vec;
    logic [O-1:0]   cls;
    logic           vec_pass;
    logic           start_ok;
    logic           load_ok;

    // Class of one IEEE-754 single: 1 iff non-negative and magnitude >= THRESH.
    // For non-negative floats the magnitude bits order like unsigned integers,
    // so a plain unsigned compare suffices; any sign-set value (incl. -0) is 0.
    function automatic logic class_of(input logic [31:0] y);
        return (y[31] == 1'b0) && (y[30:0] >= THRESH[30:0]);
    endfunction

    assign ld_ready  = !busy;
    assign load_ok   = ld_valid && ld_ready;
    assign start_ok  = start && (state == S_IDLE);
    assign n_clamp   = (n_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_vec;
    assign done_rise = net_done && !net_done_p1;
    assign wd_expire = (wd_cnt == WDW'(TIMEOUT - 1));
    assign last_vec  = ({1'b0, idx} == (n_run - (AW+1)'(1)));
    assign net_start = (state == S_ISSUE);
    assign rd_y      = res_buf[rd_addr];

    // Classify the stored result of the current vector, one bit per output.
    always_comb begin
        cls = '0;
        for (int j = 0; j < O; j++) begin
            cls[j] = class_of(res_buf[idx][32*j +: 32]);
        end
    end

    assign vec_pass = (cls == exp_buf[idx]);

    // Next-state and next-index logic of the run sequencer.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    idx_nx   = '0;
                    state_nx = (n_clamp == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // A completion edge in the same cycle as expiry still wins.
                if (done_rise) begin
                    state_nx = S_CHECK;
                end else if (wd_expire) begin
                    state_nx = S_FIN;
                end
            end
            S_CHECK: begin
                if (last_vec || (sof && !vec_pass)) begin
                    state_nx = S_FIN;
                end else begin
                    idx_nx   = idx + AW'(1);
                    state_nx = S_ISSUE;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Run control: index, mode capture, watchdog, handshake outputs, counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            n_run       <= '0;
            sof         <= 1'b0;
            wd_cnt      <= '0;
            net_done_p1 <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            net_x       <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            idx         <= idx_nx;
            net_done_p1 <= net_done;
            // busy and done are registered so that busy falls exactly when done pulses.
            busy        <= (state_nx != S_IDLE);
            done        <= (state == S_FIN);

            if (state_nx == S_ISSUE) begin
                net_x <= in_buf[idx_nx];
            end

            if (state == S_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end

            if (start_ok) begin
                n_run       <= n_clamp;
                sof         <= stop_on_fail;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                err_timeout <= 1'b0;
            end

            if ((state == S_WAIT) && !done_rise && wd_expire) begin
                err_timeout <= 1'b1;
            end

            if (state == S_CHECK) begin
                if (vec_pass) begin
                    pass_cnt <= pass_cnt + (AW+1)'(1);
                end else begin
                    fail_cnt <= fail_cnt + (AW+1)'(1);
                end
            end
        end
    end

    // Vector/label load port and result capture on the net completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                in_buf[k]  <= '0;
                exp_buf[k] <= '0;
                res_buf[k] <= '0;
            end
        end else begin
            if (load_ok) begin
                in_buf[ld_addr]  <= ld_x;
                exp_buf[ld_addr] <= ld_exp;
            end
            if ((state == S_WAIT) && done_rise) begin
                res_buf[idx] <= net_y;
            end
        end
    end

endmodule

// File: tb/tb_net_batch_runner.sv
// Self-checking bench for net_batch_runner with a behavioural net model.
module tb_net_batch_runner;

    localparam int AW  = 2;
    localparam int I   = 2;
    localparam int O   = 1;
    localparam int LAT = 5;
    localparam logic [31:0] ONE  = 32'h3f800000;
    localparam logic [31:0] ZERO = 32'h00000000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [AW-1:0]   ld_addr = '0;
    logic [32*I-1:0] ld_x = '0;
    logic [O-1:0]    ld_exp = '0;
    logic [AW:0]     n_vec = '0;
    logic            stop_on_fail = 1'b0;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [AW:0]     pass_cnt;
    logic [AW:0]     fail_cnt;
    logic            err_timeout;
    logic [AW-1:0]   rd_addr = '0;
    logic [32*O-1:0] rd_y;
    logic            net_start;
    logic [32*I-1:0] net_x;
    logic [32*O-1:0] net_y = '0;
    logic            net_done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        hang = 1'b0;
    logic        force_y = 1'b0;
    logic [31:0] forced_val = '0;
    int          mcnt = 0;
    logic        cnt_clr = 1'b0;
    int          nstart_cnt = 0;
    int          done_cnt = 0;

    net_batch_runner #(
        .I(I), .O(O), .AW(AW), .THRESH(32'h3f000000), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_x(ld_x), .ld_exp(ld_exp),
        .n_vec(n_vec), .stop_on_fail(stop_on_fail), .start(start),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_timeout(err_timeout), .rd_addr(rd_addr), .rd_y(rd_y),
        .net_start(net_start), .net_x(net_x), .net_y(net_y), .net_done(net_done)
    );

    always #5 clk = ~clk;

    // Net model: XOR of two float lanes (0.0/1.0), done pulse LAT cycles after start.
    always @(posedge clk) begin
        net_done <= 1'b0;
        if (net_start && !hang) begin
            mcnt <= LAT;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                net_done <= 1'b1;
                net_y <= force_y ? forced_val :
                         ((net_x[31:0] != net_x[63:32]) ? ONE : ZERO);
            end
        end
    end

    // Event counters for net_start and done pulses.
    always @(posedge clk) begin
        if (cnt_clr) begin
            nstart_cnt <= 0;
            done_cnt   <= 0;
        end else begin
            if (net_start) nstart_cnt <= nstart_cnt + 1;
            if (done)      done_cnt   <= done_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, req);
        end
    endtask

    task automatic load(input int a, input logic [31:0] x0, input logic [31:0] x1, input logic e);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = AW'(a);
        ld_x     = {x1, x0};
        ld_exp   = e;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic load_xor(input logic e1);
        load(0, ZERO, ZERO, 1'b0);
        load(1, ZERO, ONE,  e1);
        load(2, ONE,  ZERO, 1'b1);
        load(3, ONE,  ONE,  1'b0);
    endtask

    // Start pulse in cycle 0; returns at the falling edge of cycle 1.
    task automatic kick(input logic [AW:0] n, input logic s);
        @(negedge clk);
        n_vec        = n;
        stop_on_fail = s;
        start        = 1'b1;
        cnt_clr      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cnt_clr = 1'b0;
    endtask

    // cyc = cycles from the start cycle to the cycle in which done is high.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    typedef struct {
        logic [31:0] y;
        logic        e;
        int          p;
        int          f;
    } thr_t;

    thr_t tv[7];

    initial begin
        int cyc;

        tv[0] = '{32'h3f000000, 1'b1, 1, 0};
        tv[1] = '{32'h3effffff, 1'b0, 1, 0};
        tv[2] = '{32'hbf800000, 1'b0, 1, 0};
        tv[3] = '{32'h3effffff, 1'b1, 0, 1};
        tv[4] = '{32'h80000000, 1'b0, 1, 0};
        tv[5] = '{32'h7f800000, 1'b1, 1, 0};
        tv[6] = '{32'h3f800000, 1'b0, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_net_start", {63'd0, net_start}, 64'd0);
        chk("rst_err", {63'd0, err_timeout}, 64'd0);
        chk("rst_pass", 64'(pass_cnt), 64'd0);
        chk("rst_fail", 64'(fail_cnt), 64'd0);
        chk("rst_net_x", 64'(net_x), 64'd0);
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        rst_n = 1'b1;

        // XOR batch
        load_xor(1'b1);
        kick(3'd4, 1'b0);
        wait_done(cyc);
        repeat (3) @(negedge clk);
        chk("xor_pass", 64'(pass_cnt), 64'd4);
        chk("xor_fail", 64'(fail_cnt), 64'd0);
        chk("xor_done_once", 64'(done_cnt), 64'd1);
        chk("xor_nstart", 64'(nstart_cnt), 64'd4);
        chk("xor_err", {63'd0, err_timeout}, 64'd0);
        chk("xor_busy_after", {63'd0, busy}, 64'd0);
        rd_addr = 2'd1; #1;
        chk("xor_rd_y1", 64'(rd_y), 64'(ONE));
        rd_addr = 2'd3; #1;
        chk("xor_rd_y3", 64'(rd_y), 64'(ZERO));

        // Stop-on-fail, then run-all, with exp[1] wrong
        load(1, ZERO, ONE, 1'b0);
        kick(3'd4, 1'b1);
        wait_done(cyc);
        repeat (3) @(negedge clk);
        chk("sof_pass", 64'(pass_cnt), 64'd1);
        chk("sof_fail", 64'(fail_cnt), 64'd1);
        chk("sof_nstart", 64'(nstart_cnt), 64'd2);
        chk("sof_done_once", 64'(done_cnt), 64'd1);
        kick(3'd4, 1'b0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        chk("all_pass", 64'(pass_cnt), 64'd3);
        chk("all_fail", 64'(fail_cnt), 64'd1);
        chk("all_nstart", 64'(nstart_cnt), 64'd4);

        // Busy guards: writes and start while running are ignored
        load(1, ZERO, ONE, 1'b1);
        kick(3'd4, 1'b0);
        @(negedge clk);
        chk("guard_busy", {63'd0, busy}, 64'd1);
        chk("guard_ld_ready", {63'd0, ld_ready}, 64'd0);
        ld_valid = 1'b1; ld_addr = 2'd3; ld_x = {ZERO, ONE}; ld_exp = 1'b0;
        start = 1'b1; n_vec = 3'd1;
        @(negedge clk);
        ld_valid = 1'b0; start = 1'b0;
        wait_done(cyc);
        repeat (3) @(negedge clk);
        chk("guard_pass", 64'(pass_cnt), 64'd4);
        chk("guard_fail", 64'(fail_cnt), 64'd0);
        chk("guard_nstart", 64'(nstart_cnt), 64'd4);
        chk("guard_done_once", 64'(done_cnt), 64'd1);

        // n_vec above DEPTH is clamped
        kick(3'd7, 1'b0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        chk("clamp_nstart", 64'(nstart_cnt), 64'd4);
        chk("clamp_pass", 64'(pass_cnt), 64'd4);

        // Threshold table, single-vector runs with a forced net output
        force_y = 1'b1;
        for (int i = 0; i < 7; i++) begin
            forced_val = tv[i].y;
            load(0, ZERO, ZERO, tv[i].e);
            kick(3'd1, 1'b0);
            wait_done(cyc);
            @(negedge clk);
            chk($sformatf("thr%0d_pass", i), 64'(pass_cnt), 64'(tv[i].p));
            chk($sformatf("thr%0d_fail", i), 64'(fail_cnt), 64'(tv[i].f));
        end
        force_y = 1'b0;

        // n_vec = 0
        kick(3'd0, 1'b0);
        wait_done(cyc);
        chk("zero_latency", 64'(cyc), 64'd2);
        repeat (2) @(negedge clk);
        chk("zero_nstart", 64'(nstart_cnt), 64'd0);

        // Watchdog timeout, then the next start clears the flag
        hang = 1'b1;
        kick(3'd1, 1'b0);
        wait_done(cyc);
        chk("to_window", {63'd0, (cyc >= 18 && cyc <= 19)}, 64'd1);
        @(negedge clk);
        chk("to_err", {63'd0, err_timeout}, 64'd1);
        chk("to_pass", 64'(pass_cnt), 64'd0);
        chk("to_fail", 64'(fail_cnt), 64'd0);
        hang = 1'b0;
        kick(3'd0, 1'b0);
        wait_done(cyc);
        chk("to_cleared", {63'd0, err_timeout}, 64'd0);

        // Reset during WAIT of vector 2
        load_xor(1'b1);
        kick(3'd4, 1'b0);
        cyc = 0;
        while (nstart_cnt < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_v2", {63'd0, (nstart_cnt == 3)}, 64'd1);
        @(negedge clk);
        chk("rst_pre_pass", 64'(pass_cnt), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_net_start", {63'd0, net_start}, 64'd0);
        chk("mid_pass", 64'(pass_cnt), 64'd0);
        chk("mid_fail", 64'(fail_cnt), 64'd0);
        chk("mid_done", {63'd0, done}, 64'd0);
        rd_addr = 2'd1; #1;
        chk("mid_rd_y_cleared", 64'(rd_y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_done", 64'(done_cnt), 64'd0);
        chk("mid_idle", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
